// File: rtl/rank_score_arbiter_if.sv
// rtl/rank_score_arbiter_if.sv - score strobes in, winning-rank result out over valid/ready
interface rank_score_arbiter_if #(
    parameter int NUM_RANKS   = 13,
    parameter int SCORE_WIDTH = 11,
    parameter int IDX_WIDTH   = $clog2(NUM_RANKS)
);
    logic                             frame_start;
    logic [NUM_RANKS*SCORE_WIDTH-1:0] scores_flat;
    logic [NUM_RANKS-1:0]             score_done;
    logic [IDX_WIDTH-1:0]             rank_out;
    logic [SCORE_WIDTH-1:0]           best_score;
    logic [SCORE_WIDTH-1:0]           margin;
    logic                             no_match;
    logic                             rank_valid;
    logic                             rank_ready;
    logic                             overrun;

    modport master (
        output frame_start, scores_flat, score_done, rank_ready,
        input  rank_out, best_score, margin, no_match, rank_valid, overrun
    );

    modport slave (
        input  frame_start, scores_flat, score_done, rank_ready,
        output rank_out, best_score, margin, no_match, rank_valid, overrun
    );
endinterface

// File: rtl/rank_score_arbiter.sv
// rtl/rank_score_arbiter.sv - latches per-rank mismatch scores, serially picks the lowest, presents it
module rank_score_arbiter #(
    parameter int NUM_RANKS        = 13,
    parameter int SCORE_WIDTH      = 11,
    parameter int REJECT_THRESHOLD = 300,
    parameter int IDX_WIDTH        = $clog2(NUM_RANKS)
) (
    input  logic                clk,
    input  logic                rst,
    rank_score_arbiter_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(NUM_RANKS + 1);

    typedef enum logic [1:0] {COLLECT, SCAN, PRESENT} state_t;

    state_t                 state_q, state_d;
    logic [NUM_RANKS-1:0]   pending_q, pending_d;
    logic [SCORE_WIDTH-1:0] score_q [NUM_RANKS];
    logic [SCORE_WIDTH-1:0] score_d [NUM_RANKS];
    logic [CNT_WIDTH-1:0]   scan_idx_q, scan_idx_d;
    logic [SCORE_WIDTH-1:0] best_q, best_d, second_q, second_d;
    logic [IDX_WIDTH-1:0]   best_idx_q, best_idx_d;
    logic [IDX_WIDTH-1:0]   rank_out_q, rank_out_d;
    logic [SCORE_WIDTH-1:0] best_score_q, best_score_d, margin_q, margin_d;
    logic                   no_match_q, no_match_d;
    logic                   rank_valid_q, rank_valid_d;
    logic                   overrun_q, overrun_d;
    logic [SCORE_WIDTH-1:0] cur_score;
    logic                   accept, collecting;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        for (int i = 0; i < NUM_RANKS; i++) score_d[i] = score_q[i];
        scan_idx_d   = scan_idx_q;
        best_d       = best_q;
        second_d     = second_q;
        best_idx_d   = best_idx_q;
        rank_out_d   = rank_out_q;
        best_score_d = best_score_q;
        margin_d     = margin_q;
        no_match_d   = no_match_q;
        rank_valid_d = rank_valid_q;
        overrun_d    = overrun_q;
        cur_score    = '0;

        accept     = (state_q == PRESENT) && rank_valid_q && bus.rank_ready;
        collecting = (state_q == COLLECT) || bus.frame_start;

        // A new frame starts from an empty mask; its own strobes still count.
        if (bus.frame_start || accept) pending_d = '0;
        if (collecting) begin
            for (int i = 0; i < NUM_RANKS; i++) begin
                if (bus.score_done[i]) begin
                    score_d[i]   = bus.scores_flat[i*SCORE_WIDTH +: SCORE_WIDTH];
                    pending_d[i] = 1'b1;
                end
            end
        end else if (|bus.score_done) begin
            overrun_d = 1'b1;
        end

        for (int i = 0; i < NUM_RANKS; i++) begin
            if (scan_idx_q == CNT_WIDTH'(i)) cur_score = score_q[i];
        end

        if (bus.frame_start) begin
            state_d      = COLLECT;
            rank_valid_d = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (&pending_d) begin
                        state_d    = SCAN;
                        scan_idx_d = '0;
                        best_d     = '1;
                        second_d   = '1;
                        best_idx_d = '0;
                    end
                end
                SCAN: begin
                    // One extra step after the last rank moves the finished result to the outputs.
                    if (scan_idx_q == CNT_WIDTH'(NUM_RANKS)) begin
                        state_d      = PRESENT;
                        rank_out_d   = best_idx_q;
                        best_score_d = best_q;
                        margin_d     = second_q - best_q;
                        no_match_d   = best_q > SCORE_WIDTH'(REJECT_THRESHOLD);
                        rank_valid_d = 1'b1;
                    end else begin
                        if (cur_score < best_q) begin
                            second_d   = best_q;
                            best_d     = cur_score;
                            best_idx_d = IDX_WIDTH'(scan_idx_q);
                        end else if (cur_score < second_q) begin
                            second_d = cur_score;
                        end
                        scan_idx_d = scan_idx_q + 1'b1;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        state_d      = COLLECT;
                        rank_valid_d = 1'b0;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= COLLECT;
            pending_q    <= '0;
            for (int i = 0; i < NUM_RANKS; i++) score_q[i] <= '0;
            scan_idx_q   <= '0;
            best_q       <= '0;
            second_q     <= '0;
            best_idx_q   <= '0;
            rank_out_q   <= '0;
            best_score_q <= '0;
            margin_q     <= '0;
            no_match_q   <= 1'b0;
            rank_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            for (int i = 0; i < NUM_RANKS; i++) score_q[i] <= score_d[i];
            scan_idx_q   <= scan_idx_d;
            best_q       <= best_d;
            second_q     <= second_d;
            best_idx_q   <= best_idx_d;
            rank_out_q   <= rank_out_d;
            best_score_q <= best_score_d;
            margin_q     <= margin_d;
            no_match_q   <= no_match_d;
            rank_valid_q <= rank_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.rank_out   = rank_out_q;
    assign bus.best_score = best_score_q;
    assign bus.margin     = margin_q;
    assign bus.no_match   = no_match_q;
    assign bus.rank_valid = rank_valid_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_rank_score_arbiter.sv
// tb/tb_rank_score_arbiter.sv - directed and random rounds checked against a min/second-min model
module tb_rank_score_arbiter;
    localparam int N  = 13;
    localparam int SW = 11;
    localparam int IW = $clog2(N);
    localparam int TH = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rank_score_arbiter_if #(.NUM_RANKS(N), .SCORE_WIDTH(SW), .IDX_WIDTH(IW)) bus ();
    rank_score_arbiter #(.NUM_RANKS(N), .SCORE_WIDTH(SW), .REJECT_THRESHOLD(TH), .IDX_WIDTH(IW))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int pass_cnt  = 0;
    int total_cnt = 0;
    int stim [N];
    int mdl  [N];
    logic [N-1:0] mpend;

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        total_cnt++;
        assert (obs === 32'(expv)) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    // Winner is the first index holding the minimum; second is the minimum of everything else.
    task automatic model_result(output int e_idx, output int e_best, output int e_margin, output int e_nm);
        int second;
        e_idx = 0;
        e_best = mdl[0];
        for (int i = 1; i < N; i++) if (mdl[i] < e_best) begin e_best = mdl[i]; e_idx = i; end
        second = (1 << SW) - 1;
        for (int j = 0; j < N; j++) if (j != e_idx && mdl[j] < second) second = mdl[j];
        e_margin = second - e_best;
        e_nm = (e_best > TH) ? 1 : 0;
    endtask

    // Called at a negedge; drives one cycle of strobes and returns at the following negedge.
    task automatic drive(input logic [N-1:0] mask, input logic fs, input logic upd);
        if (fs) mpend = '0;
        for (int i = 0; i < N; i++) begin
            bus.scores_flat[i*SW +: SW] = SW'(stim[i]);
            if (upd && mask[i]) begin mdl[i] = stim[i]; mpend[i] = 1'b1; end
        end
        bus.score_done  = mask;
        bus.frame_start = fs;
        @(negedge clk);
        bus.score_done  = '0;
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int expect_lat);
        int got;
        got = -1;
        for (int c = 1; c <= 40; c++) begin
            if (bus.rank_valid === 1'b1) break;
            @(negedge clk);
            if (bus.rank_valid === 1'b1) begin got = c; break; end
        end
        chk(tag, got, expect_lat);
    endtask

    task automatic check_result(input string tag);
        int e_idx, e_best, e_margin, e_nm;
        model_result(e_idx, e_best, e_margin, e_nm);
        chk({tag, "_valid"},  bus.rank_valid, 1);
        chk({tag, "_rank"},   bus.rank_out,   e_idx);
        chk({tag, "_best"},   bus.best_score, e_best);
        chk({tag, "_margin"}, bus.margin,     e_margin);
        chk({tag, "_nomatch"}, bus.no_match,  e_nm);
    endtask

    task automatic accept(input string tag);
        bus.rank_ready = 1'b1;
        @(negedge clk);
        bus.rank_ready = 1'b0;
        chk({tag, "_valid_drop"}, bus.rank_valid, 0);
    endtask

    initial begin
        logic [N-1:0] mask;
        logic [31:0]  held_rank, held_best, held_margin, held_nm;
        int stable;
        bus.frame_start = 1'b0;
        bus.scores_flat = '0;
        bus.score_done  = '0;
        bus.rank_ready  = 1'b0;
        mpend = '0;
        for (int i = 0; i < N; i++) begin mdl[i] = 0; stim[i] = 0; end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_valid", bus.rank_valid, 0);
        chk("rst_rank", bus.rank_out, 0);
        chk("rst_best", bus.best_score, 0);
        chk("rst_margin", bus.margin, 0);
        chk("rst_nomatch", bus.no_match, 0);
        chk("rst_overrun", bus.overrun, 0);

        // Distinct scores, all strobes in one cycle
        for (int i = 0; i < N; i++) stim[i] = 500 - 10 * i;
        drive('1, 1'b0, 1'b1);
        wait_valid("distinct_latency", 14);
        check_result("distinct");
        chk("distinct_rank_const", bus.rank_out, 12);
        chk("distinct_margin_const", bus.margin, 10);
        accept("distinct");

        // Tie at ranks 3 and 7, staggered strobes, then backpressure
        for (int i = 0; i < N; i++) stim[i] = 200;
        stim[3] = 40;
        stim[7] = 40;
        for (int i = 0; i < N; i++) drive(N'(1) << i, 1'b0, 1'b1);
        wait_valid("tie_latency", 14);
        check_result("tie");
        chk("tie_rank_const", bus.rank_out, 3);
        held_rank = bus.rank_out; held_best = bus.best_score;
        held_margin = bus.margin; held_nm = bus.no_match;
        stable = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rank_valid !== 1'b1 || bus.rank_out !== held_rank || bus.best_score !== held_best ||
                bus.margin !== held_margin || bus.no_match !== held_nm) stable = 0;
        end
        chk("backpressure_stable", stable, 1);
        accept("tie");
        chk("held_after_accept", bus.best_score, 40);

        // Abort: 12 ranks, frame_start, a lone rank 12 must not complete the round
        for (int i = 0; i < N; i++) stim[i] = 100 + i;
        drive(N'(13'h0FFF), 1'b0, 1'b1);
        drive('0, 1'b1, 1'b0);
        drive(N'(13'h1000), 1'b0, 1'b1);
        stable = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rank_valid !== 1'b0) stable = 0;
        end
        chk("abort_no_result", stable, 1);
        for (int i = 0; i < N; i++) stim[i] = 900;
        stim[5] = 10;
        drive('1, 1'b0, 1'b1);
        wait_valid("abort_latency", 14);
        check_result("abort");
        chk("abort_margin_const", bus.margin, 890);
        accept("abort");
        stable = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rank_valid !== 1'b0) stable = 0;
        end
        chk("abort_single_result", stable, 1);

        // Overrun: strobe rank 2 with a winning score during SCAN; it must be ignored
        for (int i = 0; i < N; i++) stim[i] = $urandom_range(1, 2047);
        drive('1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        stim[2] = 0;
        drive(N'(13'h0004), 1'b0, 1'b0);
        chk("overrun_set", bus.overrun, 1);
        wait_valid("overrun_latency", 10);
        check_result("overrun");
        accept("overrun");

        // Random rounds; odd rounds use a tiny score range to force ties
        for (int r = 0; r < 6; r++) begin
            mpend = '0;
            for (int guard = 0; guard < 60 && mpend != '1; guard++) begin
                for (int i = 0; i < N; i++)
                    stim[i] = (r % 2 == 1) ? $urandom_range(0, 7) : $urandom_range(0, 2047);
                mask = N'($urandom);
                if (guard == 59) mask = '1;
                drive(mask, 1'b0, 1'b1);
            end
            wait_valid($sformatf("rand%0d_latency", r), 14);
            check_result($sformatf("rand%0d", r));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept($sformatf("rand%0d", r));
        end
        chk("overrun_sticky", bus.overrun, 1);

        // Asynchronous reset while presenting
        for (int i = 0; i < N; i++) stim[i] = 50 + i;
        drive('1, 1'b0, 1'b1);
        wait_valid("areset_latency", 14);
        #2 rst = 1'b1;
        #1;
        chk("areset_valid", bus.rank_valid, 0);
        chk("areset_rank", bus.rank_out, 0);
        chk("areset_best", bus.best_score, 0);
        chk("areset_margin", bus.margin, 0);
        chk("areset_nomatch", bus.no_match, 0);
        chk("areset_overrun", bus.overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
